// File: rtl/mult_scoreboard.sv
// Self-checking harness for a pipelined multiplier: issues operand vectors, queues the
// expected products, and grades the DUT results that return LAT cycles later.
module mult_scoreboard #(
    parameter int W        = 16,
    parameter int LAT      = 4,
    parameter int DEPTH    = 8,
    parameter int SIGNED   = 0,
    parameter int SELF_REF = 0,
    parameter int CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_a,
    input  logic [W-1:0]       in_b,
    input  logic [2*W-1:0]     in_exp,
    input  logic               in_last,
    output logic [W-1:0]       dut_a,
    output logic [W-1:0]       dut_b,
    output logic               dut_valid,
    input  logic [2*W-1:0]     dut_product,
    output logic [CNT_W-1:0]   run_cnt,
    output logic [CNT_W-1:0]   pass_cnt,
    output logic [CNT_W-1:0]   fail_cnt,
    output logic [CNT_W-1:0]   first_fail_idx,
    output logic [2*W-1:0]     first_fail_got,
    output logic [2*W-1:0]     first_fail_exp,
    output logic               err,
    output logic               done,
    output logic               grade
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);

    if (DEPTH < LAT + 1) begin : g_bad_depth
        $error("mult_scoreboard: DEPTH must be >= LAT+1");
    end
    if ((DEPTH & (DEPTH - 1)) != 0) begin : g_bad_pow2
        $error("mult_scoreboard: DEPTH must be a power of 2");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Low 2W bits of the product of the extended operands give the exact product.
    function automatic logic [2*W-1:0] calc_product(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] ax;
        logic signed [2*W-1:0] bx;
        if (SIGNED != 0) begin
            ax = $signed({{W{a[W-1]}}, a});
            bx = $signed({{W{b[W-1]}}, b});
        end else begin
            ax = $signed({{W{1'b0}}, a});
            bx = $signed({{W{1'b0}}, b});
        end
        return ax * bx;
    endfunction

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    state_t             state_q, state_d;
    logic [W-1:0]       dut_a_q, dut_a_d, dut_b_q, dut_b_d;
    logic               dut_valid_q, dut_valid_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]      occ_q, occ_d, occ_after_pop;
    logic [CNT_W-1:0]   run_cnt_q, run_cnt_d, pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;
    logic [CNT_W-1:0]   ff_idx_q, ff_idx_d;
    logic [2*W-1:0]     ff_got_q, ff_got_d, ff_exp_q, ff_exp_d;
    logic               err_q, err_d;
    logic [2*W-1:0]     fifo_mem [DEPTH];
    logic [2*W-1:0]     head, exp_val;
    logic               cmp_vld, sr_busy, fifo_empty, pop, xfer, mismatch, in_flight, ready_c;

    // Compare-cycle marker: dut_valid delayed by LAT cycles
    if (LAT == 0) begin : g_nolat
        assign cmp_vld = dut_valid_q;
        assign sr_busy = 1'b0;
    end else begin : g_lat
        logic [LAT-1:0] vld_sr_q, vld_sr_d;
        always_comb begin
            vld_sr_d = (vld_sr_q << 1) | LAT'(dut_valid_q);
        end
        always_ff @(posedge clk) begin
            if (rst) vld_sr_q <= '0;
            else     vld_sr_q <= vld_sr_d;
        end
        assign cmp_vld = vld_sr_q[LAT-1];
        assign sr_busy = |vld_sr_q;
    end

    always_comb begin
        fifo_empty    = (occ_q == '0);
        head          = fifo_mem[rd_ptr_q];
        pop           = cmp_vld && !fifo_empty;
        occ_after_pop = occ_q - OW'(pop);
        ready_c       = (state_q == S_RUN) && (occ_after_pop < OW'(DEPTH));
        xfer          = in_valid && ready_c;
        exp_val       = (SELF_REF != 0) ? calc_product(in_a, in_b) : in_exp;
        // Case inequality so an X/Z result from the DUT grades as a failure
        mismatch      = fifo_empty || (dut_product !== head);
        in_flight     = dut_valid_q || sr_busy;
    end

    always_comb begin
        state_d     = state_q;
        dut_a_d     = dut_a_q;
        dut_b_d     = dut_b_q;
        dut_valid_d = xfer;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_after_pop + OW'(xfer);
        run_cnt_d   = run_cnt_q;
        pass_cnt_d  = pass_cnt_q;
        fail_cnt_d  = fail_cnt_q;
        ff_idx_d    = ff_idx_q;
        ff_got_d    = ff_got_q;
        ff_exp_d    = ff_exp_q;
        err_d       = err_q;

        if (xfer) begin
            dut_a_d  = in_a;
            dut_b_d  = in_b;
            wr_ptr_d = next_ptr(wr_ptr_q);
        end
        if (pop) rd_ptr_d = next_ptr(rd_ptr_q);

        if (cmp_vld) begin
            run_cnt_d = sat_inc(run_cnt_q);
            if (mismatch) begin
                fail_cnt_d = sat_inc(fail_cnt_q);
                if (!err_q) begin
                    ff_idx_d = run_cnt_q;
                    ff_got_d = dut_product;
                    ff_exp_d = fifo_empty ? '0 : head;
                end
                err_d = 1'b1;
            end else begin
                pass_cnt_d = sat_inc(pass_cnt_q);
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_RUN;
                    run_cnt_d  = '0;
                    pass_cnt_d = '0;
                    fail_cnt_d = '0;
                    ff_idx_d   = '0;
                    ff_got_d   = '0;
                    ff_exp_d   = '0;
                    err_d      = 1'b0;
                end
            end
            S_RUN:   if (xfer && in_last) state_d = S_DRAIN;
            S_DRAIN: if (!in_flight && fifo_empty) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            dut_a_q     <= '0;
            dut_b_q     <= '0;
            dut_valid_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            run_cnt_q   <= '0;
            pass_cnt_q  <= '0;
            fail_cnt_q  <= '0;
            ff_idx_q    <= '0;
            ff_got_q    <= '0;
            ff_exp_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dut_a_q     <= dut_a_d;
            dut_b_q     <= dut_b_d;
            dut_valid_q <= dut_valid_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            run_cnt_q   <= run_cnt_d;
            pass_cnt_q  <= pass_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
            ff_idx_q    <= ff_idx_d;
            ff_got_q    <= ff_got_d;
            ff_exp_q    <= ff_exp_d;
            err_q       <= err_d;
        end
    end

    // Expected-value storage holds data only; validity lives in the pointers
    always_ff @(posedge clk) begin
        if (xfer) fifo_mem[wr_ptr_q] <= exp_val;
    end

    assign in_ready       = ready_c;
    assign dut_a          = dut_a_q;
    assign dut_b          = dut_b_q;
    assign dut_valid      = dut_valid_q;
    assign run_cnt        = run_cnt_q;
    assign pass_cnt       = pass_cnt_q;
    assign fail_cnt       = fail_cnt_q;
    assign first_fail_idx = ff_idx_q;
    assign first_fail_got = ff_got_q;
    assign first_fail_exp = ff_exp_q;
    assign err            = err_q;
    assign done           = (state_q == S_DONE);
    assign grade          = (state_q == S_DONE) && (fail_cnt_q == '0);
endmodule
